// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : run-controller state codes, entry-point table, shared widths
// Revision: 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W    = 10;
  localparam int PROG_W    = 2;
  localparam int NUM_PROGS = 2 ** PROG_W;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ARM  = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

  // One program entry address per ProgSel value
  localparam logic [ADDR_W-1:0] ENTRY [NUM_PROGS] = '{
    10'h010, 10'h080, 10'h100, 10'h300
  };

endpackage
`default_nettype wire

// File: rtl/run_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_counter : executed-cycle counter with sync clear, enable, terminal flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module run_counter #(
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [CYCLE_W-1:0] count,
  output logic               tc
);

  localparam logic [CYCLE_W-1:0] TERMINAL = CYCLE_W'(MAX_CYCLES - 1);

  logic [CYCLE_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CYCLE_W'(1);
    end
  end

  assign count = r_count;
  assign tc    = (r_count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_ctrl : responder side of the CPU Start/Ack handshake (arm, run, done)
// Revision: 1.0
// ---------------------------------------------------------------------------
module run_ctrl #(
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 50000,
  parameter int ADDR_W     = cpu_pkg::ADDR_W,
  parameter int PROG_W     = cpu_pkg::PROG_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [PROG_W-1:0]  ProgSel,
  input  logic               Halt,
  input  logic               Stall,
  output logic               Ack,
  output logic               PcInit,
  output logic               PcEn,
  output logic [ADDR_W-1:0]  StartAddr,
  output logic [CYCLE_W-1:0] CycleCount,
  output logic               Timeout
);
  import cpu_pkg::*;

  state_t            r_state;
  state_t            w_next;
  logic              w_tc;
  logic              w_arming;
  logic              w_commit;
  logic              w_count_en;
  logic              w_timeout_hit;
  logic [ADDR_W-1:0] r_start_addr;
  logic              r_timeout;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (Start) w_next = ARM;
      ARM:  if (!Start) w_next = RUN;
      RUN: begin
        if (Start) begin
          w_next = ARM;
        end else if (!Stall && (Halt || w_tc)) begin
          w_next = DONE;
        end
      end
      DONE: if (Start) w_next = ARM;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    Ack    = 1'b0;
    PcInit = 1'b0;
    PcEn   = 1'b0;
    case (r_state)
      ARM:     PcInit = 1'b1;
      RUN:     PcEn   = !Stall;
      DONE:    Ack    = 1'b1;
      default: ;
    endcase
  end

  // Clearing on entry as well keeps StartAddr/CycleCount valid on the first ARM cycle
  assign w_arming      = (r_state == ARM) || (w_next == ARM);
  assign w_commit      = (r_state == RUN) && !Start && !Stall;
  // A committed Halt always counts; the watchdog cycle itself does not
  assign w_count_en    = w_commit && (Halt || !w_tc);
  assign w_timeout_hit = w_commit && !Halt && w_tc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_start_addr <= '0;
      r_timeout    <= 1'b0;
    end else if (w_arming) begin
      r_start_addr <= ADDR_W'(ENTRY[ProgSel]);
      r_timeout    <= 1'b0;
    end else if (w_timeout_hit) begin
      r_timeout    <= 1'b1;
    end
  end

  run_counter #(
    .CYCLE_W    (CYCLE_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_counter (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (w_arming),
    .en    (w_count_en),
    .count (CycleCount),
    .tc    (w_tc)
  );

  assign StartAddr = r_start_addr;
  assign Timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_run_ctrl : vector table, directed corner sequences and random model check
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_run_ctrl;

  localparam int   MAXC = 20;
  localparam logic H    = 1'b1;
  localparam logic L    = 1'b0;

  logic        Clk = 1'b0;
  logic        Reset, Start, Halt, Stall;
  logic [1:0]  ProgSel;
  logic        Ack, PcInit, PcEn, Timeout;
  logic [9:0]  StartAddr;
  logic [15:0] CycleCount;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] ent [4] = '{10'h010, 10'h080, 10'h100, 10'h300};

  always #5 Clk = ~Clk;

  run_ctrl #(
    .CYCLE_W    (16),
    .MAX_CYCLES (MAXC),
    .ADDR_W     (10),
    .PROG_W     (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ProgSel    (ProgSel),
    .Halt       (Halt),
    .Stall      (Stall),
    .Ack        (Ack),
    .PcInit     (PcInit),
    .PcEn       (PcEn),
    .StartAddr  (StartAddr),
    .CycleCount (CycleCount),
    .Timeout    (Timeout)
  );

  typedef struct {
    logic        r, s;
    logic [1:0]  p;
    logic        h, st;
    logic        a, pi, pe;
    logic [9:0]  ad;
    logic [15:0] c;
    logic        t;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t v(input logic r, s, input logic [1:0] p, input logic h, st,
                             input logic a, pi, pe, input logic [9:0] ad,
                             input logic [15:0] c, input logic t);
    vec_t x;
    x.r = r; x.s = s; x.p = p; x.h = h; x.st = st;
    x.a = a; x.pi = pi; x.pe = pe; x.ad = ad; x.c = c; x.t = t;
    return x;
  endfunction

  // Apply inputs, let one rising edge pass, settle 1 time unit past it
  task automatic drive(input logic r, s, input logic [1:0] p, input logic h, st);
    Reset = r; Start = s; ProgSel = p; Halt = h; Stall = st;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic a, pi, pe, input logic [9:0] ad,
                       input logic [15:0] c, input logic t);
    n_tests++;
    if ({Ack, PcInit, PcEn, StartAddr, CycleCount, Timeout} !== {a, pi, pe, ad, c, t}) begin
      n_fail++;
      $display("FAIL %s: got ack=%0b init=%0b en=%0b addr=%h cnt=%0d to=%0b, want ack=%0b init=%0b en=%0b addr=%h cnt=%0d to=%0b",
               nm, Ack, PcInit, PcEn, StartAddr, CycleCount, Timeout, a, pi, pe, ad, c, t);
    end
  endtask

  // Reference model: phase plus counters, advanced once per rising edge
  typedef enum int {P_IDLE, P_ARMED, P_RUNNING, P_FINISHED} phase_e;
  phase_e     m_phase;
  int         m_cnt;
  logic       m_to;
  logic [9:0] m_addr;

  task automatic model_step(input logic r, s, input logic [1:0] p, input logic h, st);
    if (r) begin
      m_phase = P_IDLE; m_cnt = 0; m_to = 1'b0; m_addr = 10'h000;
    end else if (s && m_phase != P_IDLE || m_phase == P_ARMED || (s && m_phase == P_IDLE)) begin
      // Any arming edge (or staying armed) reloads the entry and clears stats
      m_addr = ent[p]; m_cnt = 0; m_to = 1'b0;
      m_phase = s ? P_ARMED : P_RUNNING;
    end else if (m_phase == P_RUNNING && !st) begin
      if (h) begin
        m_cnt++; m_phase = P_FINISHED;
      end else if (m_cnt == MAXC - 1) begin
        m_to = 1'b1; m_phase = P_FINISHED;
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    // Table: reset, arm with ProgSel=2, halt on 10th run cycle, rearm,
    // stalled-halt run ending at count 5, reset in DONE
    tbl[0]  = v(H, H, 2'd0, L, L,  L, L, L, 10'h000, 16'd0, L);
    tbl[1]  = v(L, H, 2'd2, L, L,  L, H, L, 10'h100, 16'd0, L);
    tbl[2]  = v(L, H, 2'd2, L, L,  L, H, L, 10'h100, 16'd0, L);
    tbl[3]  = v(L, L, 2'd2, L, L,  L, L, H, 10'h100, 16'd0, L);
    for (int k = 1; k <= 9; k++)
      tbl[3 + k] = v(L, L, 2'd2, L, L,  L, L, H, 10'h100, 16'(k), L);
    tbl[13] = v(L, L, 2'd2, H, L,  H, L, L, 10'h100, 16'd10, L);
    tbl[14] = v(L, L, 2'd2, L, L,  H, L, L, 10'h100, 16'd10, L);
    tbl[15] = v(L, H, 2'd1, L, L,  L, H, L, 10'h080, 16'd0, L);
    tbl[16] = v(L, L, 2'd1, L, H,  L, L, L, 10'h080, 16'd0, L);
    tbl[17] = v(L, L, 2'd1, H, H,  L, L, L, 10'h080, 16'd0, L);
    tbl[18] = v(L, L, 2'd1, L, L,  L, L, H, 10'h080, 16'd1, L);
    tbl[19] = v(L, L, 2'd1, L, H,  L, L, L, 10'h080, 16'd1, L);
    tbl[20] = v(L, L, 2'd1, H, H,  L, L, L, 10'h080, 16'd1, L);
    tbl[21] = v(L, L, 2'd1, L, L,  L, L, H, 10'h080, 16'd2, L);
    tbl[22] = v(L, L, 2'd1, L, L,  L, L, H, 10'h080, 16'd3, L);
    tbl[23] = v(L, L, 2'd1, L, L,  L, L, H, 10'h080, 16'd4, L);
    tbl[24] = v(L, L, 2'd1, H, L,  H, L, L, 10'h080, 16'd5, L);
    tbl[25] = v(H, L, 2'd1, L, L,  L, L, L, 10'h000, 16'd0, L);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].h, tbl[i].st);
      check($sformatf("vec%0d", i), tbl[i].a, tbl[i].pi, tbl[i].pe, tbl[i].ad, tbl[i].c, tbl[i].t);
    end

    // Watchdog: 20 unstalled cycles without Halt
    drive(L, H, 2'd3, L, L); check("wd_arm", L, H, L, 10'h300, 16'd0, L);
    drive(L, L, 2'd3, L, L); check("wd_run0", L, L, H, 10'h300, 16'd0, L);
    for (int i = 1; i <= MAXC - 1; i++) begin
      drive(L, L, 2'd3, L, L);
      check($sformatf("wd_run%0d", i), L, L, H, 10'h300, 16'(i), L);
    end
    drive(L, L, 2'd3, L, L); check("wd_fire", H, L, L, 10'h300, 16'd19, H);
    drive(L, L, 2'd0, H, L); check("wd_frozen", H, L, L, 10'h300, 16'd19, H);

    // Halt on the watchdog cycle wins
    drive(L, H, 2'd3, L, L); check("wd2_arm", L, H, L, 10'h300, 16'd0, L);
    drive(L, L, 2'd3, L, L);
    for (int i = 1; i <= MAXC - 1; i++) drive(L, L, 2'd3, L, L);
    check("wd2_cnt19", L, L, H, 10'h300, 16'd19, L);
    drive(L, L, 2'd3, H, L); check("wd2_halt", H, L, L, 10'h300, 16'd20, L);

    // Abort by Start mid-run; Start held keeps following ProgSel
    drive(L, H, 2'd0, L, L); check("ab_arm", L, H, L, 10'h010, 16'd0, L);
    drive(L, H, 2'd3, L, L); check("ab_hold", L, H, L, 10'h300, 16'd0, L);
    drive(L, H, 2'd0, L, L); check("ab_hold2", L, H, L, 10'h010, 16'd0, L);
    drive(L, L, 2'd0, L, L);
    for (int i = 0; i < 3; i++) drive(L, L, 2'd0, L, L);
    check("ab_cnt3", L, L, H, 10'h010, 16'd3, L);
    drive(L, H, 2'd0, L, L); check("ab_restart", L, H, L, 10'h010, 16'd0, L);
    drive(L, L, 2'd0, L, L);
    drive(L, L, 2'd0, L, L); check("ab_cnt1", L, L, H, 10'h010, 16'd1, L);
    drive(L, H, 2'd0, H, L); check("ab_start_halt", L, H, L, 10'h010, 16'd0, L);

    // Reset mid-run, then stay idle
    drive(L, L, 2'd0, L, L);
    drive(L, L, 2'd0, L, H); check("rr_stall", L, L, L, 10'h010, 16'd0, L);
    drive(H, L, 2'd0, L, L); check("rr_reset", L, L, L, 10'h000, 16'd0, L);
    drive(L, L, 2'd2, H, L); check("rr_idle", L, L, L, 10'h000, 16'd0, L);

    // Randomized run against the reference model
    drive(H, L, 2'd0, L, L);
    model_step(H, L, 2'd0, L, L);
    for (int i = 0; i < 3000; i++) begin
      logic r, s, h, st;
      logic [1:0] p;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 39) == 0);
      h  = ($urandom_range(0, 31) == 0);
      st = ($urandom_range(0, 3) == 0);
      p  = 2'($urandom_range(0, 3));
      drive(r, s, p, h, st);
      model_step(r, s, p, h, st);
      check($sformatf("rnd%0d", i), m_phase == P_FINISHED, m_phase == P_ARMED,
            (m_phase == P_RUNNING) && !st, m_addr, 16'(m_cnt), m_to);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
